// File: rtl/pixel_seq_ctrl.sv
// Acquisition sequencer for PIXEL_CONTROL: reset/store windows,
// optional trigger gating, then register-out and memory-set readout.
module pixel_seq_ctrl #(
    parameter int RESET_LEN   = 1,
    parameter int STORE_WIDTH = 76,
    parameter int REGOUT_LEN  = 10,
    parameter int MEM_PULSE   = 5,
    parameter int MEM_GAP     = 10,
    parameter int MAX_MEM     = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       ABORT,
    input  logic [3:0] NUM_SAMPLE,
    input  logic [3:0] READ_MEM_CFG,
    input  logic       COMP_MODE,
    input  logic       TRG_MODE_CFG,
    input  logic       TRG_DET,
    input  logic       PIX_RESET_BUSY,
    input  logic       MEM_SET_DONE,
    input  logic       LAST_MEM,
    output logic       PIX_RESET,
    output logic       PIX_STORE,
    output logic       COMP_EN_SEL,
    output logic       MEM_SET_EN,
    output logic       MEM_SET_CLR,
    output logic       REGOUT_EN,
    output logic [3:0] READ_MEM,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic [3:0] SAMPLE_CNT
);

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

    localparam int TMAX = max2(
        max2(max2(RESET_LEN, STORE_WIDTH), max2(REGOUT_LEN, MEM_PULSE)),
        max2(MEM_GAP, TIMEOUT));
    localparam int TW = $clog2(TMAX + 1);
    localparam int MW = $clog2(MAX_MEM + 1);

    typedef logic [TW-1:0] tmr_t;
    typedef logic [MW-1:0] mcnt_t;

    localparam tmr_t  RST_END   = tmr_t'(RESET_LEN - 1);
    localparam tmr_t  STO_END   = tmr_t'(STORE_WIDTH - 1);
    localparam tmr_t  ROUT_END  = tmr_t'(REGOUT_LEN - 1);
    localparam tmr_t  PULSE_END = tmr_t'(MEM_PULSE - 1);
    localparam tmr_t  GAP_END   = tmr_t'(MEM_GAP - 1);
    localparam tmr_t  TO_END    = tmr_t'(TIMEOUT - 1);
    localparam mcnt_t MEM_LIM   = mcnt_t'(MAX_MEM);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARM,
        S_RST_PULSE,
        S_STORE,
        S_STORE_END,
        S_SETTLE,
        S_REGOUT,
        S_MCLR,
        S_MGAP0,
        S_MSET,
        S_MGAP,
        S_FIN
    } state_t;

    state_t     state;
    state_t     next;
    tmr_t       tmr;
    mcnt_t      mem_cnt;
    logic       last_q;
    logic [3:0] cfg_num;
    logic [3:0] cfg_rm;
    logic       cfg_comp;
    logic       cfg_trg;

    logic       accept;
    logic       zero_start;
    logic [3:0] cnt_inc;
    logic       settle_ok;
    logic       settle_to;
    logic       mset_exit;
    logic       gap_end;

    logic       pix_reset_d;
    logic       pix_store_d;
    logic       comp_d;
    logic       mem_en_d;
    logic       mem_clr_d;
    logic       regout_d;
    logic [3:0] read_mem_d;
    logic       busy_d;
    logic       done_d;
    logic       err_d;
    logic       cfg_comp_n;
    logic [3:0] cfg_rm_n;

    always_comb begin
        accept     = (state == S_IDLE) && START && !ABORT
                     && (NUM_SAMPLE != 4'd0);
        zero_start = (state == S_IDLE) && START && !ABORT
                     && (NUM_SAMPLE == 4'd0);
        cnt_inc    = (SAMPLE_CNT == 4'hF) ? 4'hF : SAMPLE_CNT + 4'd1;
        settle_ok  = (state == S_SETTLE) && !PIX_RESET_BUSY;
        settle_to  = (state == S_SETTLE) && PIX_RESET_BUSY
                     && (tmr == TO_END);
        mset_exit  = (state == S_MSET)
                     && (MEM_SET_DONE || (tmr == PULSE_END));
        gap_end    = (state == S_MGAP) && (tmr == GAP_END);
    end

    // State register plus the registered command outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            PIX_RESET   <= 1'b0;
            PIX_STORE   <= 1'b0;
            COMP_EN_SEL <= 1'b0;
            MEM_SET_EN  <= 1'b0;
            MEM_SET_CLR <= 1'b0;
            REGOUT_EN   <= 1'b0;
            READ_MEM    <= 4'd0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            state       <= next;
            PIX_RESET   <= pix_reset_d;
            PIX_STORE   <= pix_store_d;
            COMP_EN_SEL <= comp_d;
            MEM_SET_EN  <= mem_en_d;
            MEM_SET_CLR <= mem_clr_d;
            REGOUT_EN   <= regout_d;
            READ_MEM    <= read_mem_d;
            BUSY        <= busy_d;
            DONE        <= done_d;
            ERR         <= err_d;
        end
    end

    always_comb begin
        next = state;
        if (ABORT) begin
            next = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:
                    if (accept) next = S_ARM;
                S_ARM:
                    if (!cfg_trg || TRG_DET) next = S_RST_PULSE;
                S_RST_PULSE:
                    if (tmr == RST_END) next = S_STORE;
                S_STORE:
                    if (tmr == STO_END) next = S_STORE_END;
                S_STORE_END:
                    next = S_SETTLE;
                S_SETTLE:
                    if (settle_ok)
                        next = (cnt_inc == cfg_num) ? S_REGOUT : S_ARM;
                    else if (settle_to)
                        next = S_IDLE;
                S_REGOUT:
                    if (tmr == ROUT_END) next = S_MCLR;
                S_MCLR:
                    if (tmr == PULSE_END) next = S_MGAP0;
                S_MGAP0:
                    if (tmr == GAP_END) next = S_MSET;
                S_MSET:
                    if (mset_exit) next = S_MGAP;
                S_MGAP:
                    if (gap_end)
                        next = (last_q || mem_cnt == MEM_LIM) ? S_FIN
                                                               : S_MSET;
                S_FIN:
                    next = S_IDLE;
                default:
                    next = S_IDLE;
            endcase
        end
    end

    // Outputs decode the next state so they line up with the state.
    always_comb begin
        cfg_comp_n  = accept ? COMP_MODE : cfg_comp;
        cfg_rm_n    = accept ? READ_MEM_CFG : cfg_rm;
        busy_d      = (next != S_IDLE);
        pix_reset_d = (next == S_RST_PULSE) || (next == S_STORE_END);
        pix_store_d = (next == S_RST_PULSE) || (next == S_STORE)
                      || (next == S_STORE_END);
        mem_en_d    = (next == S_MSET);
        mem_clr_d   = (next == S_MCLR);
        regout_d    = (next == S_REGOUT);
        comp_d      = busy_d && cfg_comp_n;
        read_mem_d  = busy_d ? cfg_rm_n : READ_MEM;
        done_d      = (next == S_FIN) || zero_start;
        err_d       = ERR;
        if (accept)
            err_d = 1'b0;
        if (!ABORT && (settle_to
            || (gap_end && !last_q && mem_cnt == MEM_LIM)))
            err_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tmr        <= '0;
            mem_cnt    <= '0;
            last_q     <= 1'b0;
            cfg_num    <= 4'd0;
            cfg_rm     <= 4'd0;
            cfg_comp   <= 1'b0;
            cfg_trg    <= 1'b0;
            SAMPLE_CNT <= 4'd0;
        end else begin
            if (next != state || state == S_IDLE || state == S_ARM)
                tmr <= '0;
            else
                tmr <= tmr + tmr_t'(1);
            if (accept) begin
                cfg_num  <= NUM_SAMPLE;
                cfg_rm   <= READ_MEM_CFG;
                cfg_comp <= COMP_MODE;
                cfg_trg  <= TRG_MODE_CFG;
            end
            if (accept)
                SAMPLE_CNT <= 4'd0;
            else if (settle_ok && !ABORT)
                SAMPLE_CNT <= cnt_inc;
            if (state == S_REGOUT)
                mem_cnt <= '0;
            else if (mset_exit && !ABORT)
                mem_cnt <= mem_cnt + mcnt_t'(1);
            if (mset_exit)
                last_q <= LAST_MEM;
        end
    end

endmodule
